// File: rtl/counter_monitor.sv
// Sequence checker for the 4-bit up-counter outputs: locks onto the incrementing
// sequence, then flags mismatches and counts errors and 15->0 wraps.
module counter_monitor #(
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8,
    parameter int RELOCK_N = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bit_1,
    input  logic              bit_2,
    input  logic              bit_3,
    input  logic              bit_4,
    input  logic              sample_en,
    input  logic              clear,
    output logic              locked,
    output logic              mismatch,
    output logic              sticky_error,
    output logic [ERR_W-1:0]  error_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [3:0]        last_value
);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } state_e;

    localparam logic [2:0] RelockC = 3'(RELOCK_N);

    state_e             state_q, state_d;
    logic [2:0]         good_q, good_d;
    logic [3:0]         last_q, last_d;
    logic               locked_q, locked_d;
    logic               mismatch_q, mismatch_d;
    logic               sticky_q, sticky_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [WRAP_W-1:0]  wrap_q, wrap_d;

    logic [3:0]         sampled;
    logic [3:0]         expected;

    assign sampled  = {bit_4, bit_3, bit_2, bit_1};
    assign expected = last_q + 4'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            good_q     <= 3'd0;
            last_q     <= 4'd0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
            err_q      <= '0;
            wrap_q     <= '0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            last_q     <= last_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
            sticky_q   <= sticky_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        last_d     = last_q;
        mismatch_d = 1'b0;
        sticky_d   = sticky_q;
        err_d      = err_q;
        wrap_d     = wrap_q;

        if (sample_en) begin
            last_d = sampled;
            unique case (state_q)
                UNLOCKED: begin
                    good_d  = 3'd0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (sampled == expected) begin
                        good_d = good_q + 3'd1;
                        if (good_q + 3'd1 == RelockC) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = 3'd0;
                    end
                end
                LOCKED: begin
                    if (sampled == expected) begin
                        if (last_q == 4'hF && wrap_q != {WRAP_W{1'b1}}) begin
                            wrap_d = wrap_q + 1'b1;
                        end
                    end else begin
                        mismatch_d = 1'b1;
                        sticky_d   = 1'b1;
                        good_d     = 3'd0;
                        state_d    = ACQUIRE;
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    good_d  = 3'd0;
                end
            endcase
        end

        // Clear wins over any same-cycle increment or sticky set.
        if (clear) begin
            err_d    = '0;
            wrap_d   = '0;
            sticky_d = 1'b0;
        end

        locked_d = (state_d == LOCKED);
    end

    assign locked       = locked_q;
    assign mismatch     = mismatch_q;
    assign sticky_error = sticky_q;
    assign error_count  = err_q;
    assign wrap_count   = wrap_q;
    assign last_value   = last_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Table-driven bench for counter_monitor: each vector's expected outputs go through
// a scoreboard queue and are compared one cycle later; a second instance has ERR_W=2.
module tb_counter_monitor;

    typedef struct {
        logic       rst;
        logic       en;
        logic       clr;
        logic [3:0] val;
        logic       lk;
        logic       mis;
        logic       st;
        logic [7:0] err;
        logic [7:0] wrap;
        logic [3:0] last;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       sampleEn;
    logic       clearIn;
    logic [3:0] stimVal;

    logic       locked, mismatch, stickyError;
    logic [7:0] errorCount, wrapCount;
    logic [3:0] lastValue;

    logic       locked2, mismatch2, stickyError2;
    logic [1:0] errorCount2;
    logic [7:0] wrapCount2;
    logic [3:0] lastValue2;

    vec_t vecs[$];
    vec_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    counter_monitor dut (
        .clock(clock), .reset(reset),
        .bit_1(stimVal[0]), .bit_2(stimVal[1]), .bit_3(stimVal[2]), .bit_4(stimVal[3]),
        .sample_en(sampleEn), .clear(clearIn),
        .locked(locked), .mismatch(mismatch), .sticky_error(stickyError),
        .error_count(errorCount), .wrap_count(wrapCount), .last_value(lastValue)
    );

    counter_monitor #(.ERR_W(2)) dutSat (
        .clock(clock), .reset(reset),
        .bit_1(stimVal[0]), .bit_2(stimVal[1]), .bit_3(stimVal[2]), .bit_4(stimVal[3]),
        .sample_en(sampleEn), .clear(clearIn),
        .locked(locked2), .mismatch(mismatch2), .sticky_error(stickyError2),
        .error_count(errorCount2), .wrap_count(wrapCount2), .last_value(lastValue2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic addVec(input logic r, input logic e, input logic c, input logic [3:0] v,
                          input logic lk, input logic mis, input logic st,
                          input logic [7:0] err, input logic [7:0] wrap, input logic [3:0] last);
        vec_t t;
        t.rst = r; t.en = e; t.clr = c; t.val = v;
        t.lk = lk; t.mis = mis; t.st = st; t.err = err; t.wrap = wrap; t.last = last;
        vecs.push_back(t);
    endtask

    task automatic checkField(input string name, input int idx, input logic [7:0] act,
                              input logic [7:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        @(negedge clock);
        reset    = t.rst;
        sampleEn = t.en;
        clearIn  = t.clr;
        stimVal  = t.val;
        expQ.push_back(t);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        logic [7:0] satErr;
        assertCount++;
        if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard vec %0d: got empty queue, expected one entry", idx);
            return;
        end
        e = expQ.pop_front();
        satErr = (e.err > 8'd3) ? 8'd3 : e.err;
        checkField("locked",       idx, {7'd0, locked},      {7'd0, e.lk});
        checkField("mismatch",     idx, {7'd0, mismatch},    {7'd0, e.mis});
        checkField("sticky_error", idx, {7'd0, stickyError}, {7'd0, e.st});
        checkField("error_count",  idx, errorCount,          e.err);
        checkField("wrap_count",   idx, wrapCount,           e.wrap);
        checkField("last_value",   idx, {4'd0, lastValue},   {4'd0, e.last});
        checkField("sat_error_count", idx, {6'd0, errorCount2}, satErr);
    endtask

    initial begin
        logic [3:0] last;
        logic [7:0] err;
        logic [3:0] bad;

        reset = 1'b1; sampleEn = 1'b0; clearIn = 1'b0; stimVal = 4'd0;

        // Reset, then acquire and lock on 0,1,2,3.
        repeat (3) addVec(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 4'd0);
        addVec(0, 1, 0, 4'd0, 0, 0, 0, 0, 0, 4'd0);
        addVec(0, 1, 0, 4'd1, 0, 0, 0, 0, 0, 4'd1);
        addVec(0, 1, 0, 4'd2, 1, 0, 0, 0, 0, 4'd2);
        addVec(0, 1, 0, 4'd3, 1, 0, 0, 0, 0, 4'd3);

        // Run through 15 -> 0 while locked: one wrap.
        for (int k = 4; k <= 15; k++) addVec(0, 1, 0, 4'(k), 1, 0, 0, 0, 0, 4'(k));
        addVec(0, 1, 0, 4'd0, 1, 0, 0, 0, 1, 4'd0);
        for (int k = 1; k <= 5; k++) addVec(0, 1, 0, 4'(k), 1, 0, 0, 0, 1, 4'(k));

        // Skip from 5 to 7, then relock on 8,9.
        addVec(0, 1, 0, 4'd7, 0, 1, 1, 1, 1, 4'd7);
        addVec(0, 1, 0, 4'd8, 0, 0, 1, 1, 1, 4'd8);
        addVec(0, 1, 0, 4'd9, 1, 0, 1, 1, 1, 4'd9);

        // Hold with random bits, then resume with the right value.
        repeat (10) addVec(0, 0, 0, 4'($urandom_range(0, 15)), 1, 0, 1, 1, 1, 4'd9);
        addVec(0, 1, 0, 4'd10, 1, 0, 1, 1, 1, 4'd10);

        // Three more errors (jump back, skip, stall) to reach error_count=4.
        addVec(0, 1, 0, 4'd0, 0, 1, 1, 2, 1, 4'd0);
        addVec(0, 1, 0, 4'd1, 0, 0, 1, 2, 1, 4'd1);
        addVec(0, 1, 0, 4'd2, 1, 0, 1, 2, 1, 4'd2);
        addVec(0, 1, 0, 4'd5, 0, 1, 1, 3, 1, 4'd5);
        addVec(0, 1, 0, 4'd6, 0, 0, 1, 3, 1, 4'd6);
        addVec(0, 1, 0, 4'd7, 1, 0, 1, 3, 1, 4'd7);
        addVec(0, 1, 0, 4'd7, 0, 1, 1, 4, 1, 4'd7);
        addVec(0, 1, 0, 4'd8, 0, 0, 1, 4, 1, 4'd8);
        addVec(0, 1, 0, 4'd9, 1, 0, 1, 4, 1, 4'd9);

        // Clear coincident with a mismatch: pulse survives, counters and sticky clear.
        addVec(0, 1, 1, 4'd15, 0, 1, 0, 0, 0, 4'd15);
        addVec(0, 1, 0, 4'd0,  0, 0, 0, 0, 0, 4'd0);
        addVec(0, 1, 0, 4'd1,  1, 0, 0, 0, 0, 4'd1);

        // Clear coincident with a wrap.
        for (int k = 2; k <= 15; k++) addVec(0, 1, 0, 4'(k), 1, 0, 0, 0, 0, 4'(k));
        addVec(0, 1, 1, 4'd0, 1, 0, 0, 0, 0, 4'd0);
        addVec(0, 1, 0, 4'd1, 1, 0, 0, 0, 0, 4'd1);

        // Five mismatch/relock rounds; one relock crosses 15->0 in ACQUIRE (no wrap).
        last = 4'd1;
        err  = 8'd0;
        for (int k = 0; k < 5; k++) begin
            bad = last + 4'd2;
            err = err + 8'd1;
            addVec(0, 1, 0, bad,         0, 1, 1, err, 0, bad);
            addVec(0, 1, 0, bad + 4'd1,  0, 0, 1, err, 0, bad + 4'd1);
            addVec(0, 1, 0, bad + 4'd2,  1, 0, 1, err, 0, bad + 4'd2);
            last = bad + 4'd2;
        end

        // Clear still acts while sampling is held.
        addVec(0, 0, 1, 4'd11, 1, 0, 0, 0, 0, 4'd5);
        addVec(0, 1, 0, 4'd6,  1, 0, 0, 0, 0, 4'd6);

        // Reset mid-LOCKED, then reacquire from UNLOCKED.
        addVec(1, 1, 0, 4'd7,  0, 0, 0, 0, 0, 4'd0);
        addVec(0, 1, 0, 4'd8,  0, 0, 0, 0, 0, 4'd8);
        addVec(0, 1, 0, 4'd9,  0, 0, 0, 0, 0, 4'd9);
        addVec(0, 1, 0, 4'd10, 1, 0, 0, 0, 0, 4'd10);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
